// File: rtl/serializer.sv
// Parallel-to-serial stage of the SERDES path.
// Captures one frame in a single transfer, then emits its words in order, word 0 first.
module serializer #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_last
);

  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [BIT_WIDTH-1:0] r_data [N_SAMPLES-1:0];

  logic w_at_last;
  logic w_capture;
  logic w_advance;

  assign w_at_last = (r_idx == LAST);
  assign w_capture = (r_state == IDLE) && recv_val;
  assign w_advance = (r_state == SEND) && send_rdy;

  // State and index: capture in IDLE, step per accepted word in SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else if (w_capture) begin
      r_state <= SEND;
      r_idx   <= '0;
    end else if (w_advance) begin
      if (w_at_last) begin
        r_state <= IDLE;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Frame storage: written only on the IDLE capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        r_data[i] <= recv_msg[i];
      end
    end
  end

  generate
    if (N_SAMPLES == 1) begin : g_one
      assign send_msg = r_data[0];
    end else begin : g_many
      assign send_msg = r_data[r_idx];
    end
  endgenerate

  // Outputs decode from state only; no path from send_rdy to recv_rdy
  always_comb begin
    recv_rdy  = (r_state == IDLE);
    send_val  = (r_state == SEND);
    send_last = (r_state == SEND) && w_at_last;
  end

endmodule

// File: tb/tb_serializer.sv
// Directed-vector and scoreboard bench for serializer.
// Covers reset, streaming, backpressure, ignored input, mid-frame reset, N=1.
module tb_serializer;

  localparam int N = 8;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         recv_val;
  logic         recv_rdy;
  logic [W-1:0] recv_msg [N-1:0];
  logic         send_val;
  logic         send_rdy;
  logic [W-1:0] send_msg;
  logic         send_last;

  logic         recv_val1;
  logic         recv_rdy1;
  logic [7:0]   recv_msg1 [0:0];
  logic         send_val1;
  logic         send_rdy1;
  logic [7:0]   send_msg1;
  logic         send_last1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serializer #(.N_SAMPLES(N), .BIT_WIDTH(W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .recv_msg  (recv_msg),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_msg  (send_msg),
    .send_last (send_last)
  );

  serializer #(.N_SAMPLES(1), .BIT_WIDTH(8)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val1),
    .recv_rdy  (recv_rdy1),
    .recv_msg  (recv_msg1),
    .send_val  (send_val1),
    .send_rdy  (send_rdy1),
    .send_msg  (send_msg1),
    .send_last (send_last1)
  );

  typedef struct {
    logic         rst;
    logic         rv;
    logic [W-1:0] base;
    logic         sr;
    logic         e_rdy;
    logic         e_val;
    logic [W-1:0] e_msg;
    logic         e_last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) recv_msg[i] = base + W'(i);
  endtask

  function automatic vec_t mk(input logic rst, input logic rv,
                              input logic [W-1:0] base, input logic sr,
                              input logic er, input logic ev,
                              input logic [W-1:0] em, input logic el);
    vec_t v;
    v.rst = rst; v.rv = rv; v.base = base; v.sr = sr;
    v.e_rdy = er; v.e_val = ev; v.e_msg = em; v.e_last = el;
    return v;
  endfunction

  // Idle cycle: inputs given, expected idle outputs showing word m
  task automatic idle_row(input logic rv, input logic [W-1:0] base,
                          input logic [W-1:0] m);
    vecs.push_back(mk(1'b0, rv, base, 1'b1, 1'b1, 1'b0, m, 1'b0));
  endtask

  // Send cycle showing word m; last when idx k == N-1
  task automatic send_row(input logic rv, input logic [W-1:0] base,
                          input logic sr, input logic [W-1:0] m, input int k);
    vecs.push_back(mk(1'b0, rv, base, sr, 1'b0, 1'b1, m, k == N - 1));
  endtask

  logic [W-1:0] mq[$];
  bit           lq[$];

  initial begin
    reset     = 1'b1;
    recv_val  = 1'b0;
    send_rdy  = 1'b0;
    recv_val1 = 1'b0;
    send_rdy1 = 1'b0;
    recv_msg1[0] = 8'h00;
    set_frame('0);

    // Test 1/2: idle hold, then a full frame with send_rdy high
    idle_row(1'b0, 32'h0, 32'h0);
    idle_row(1'b0, 32'h0, 32'h0);
    idle_row(1'b1, 32'h10, 32'h0);
    for (int k = 0; k < N; k++) send_row(1'b0, 32'h0, 1'b1, 32'h10 + k, k);
    idle_row(1'b0, 32'h0, 32'h10);
    // Test 3: backpressure for 3 cycles on 0x12
    idle_row(1'b1, 32'h10, 32'h10);
    send_row(1'b0, 32'h0, 1'b1, 32'h10, 0);
    send_row(1'b0, 32'h0, 1'b1, 32'h11, 1);
    for (int k = 0; k < 3; k++) send_row(1'b0, 32'h0, 1'b0, 32'h12, 2);
    for (int k = 2; k < N; k++) send_row(1'b0, 32'h0, 1'b1, 32'h10 + k, k);
    // Test 4: recv_val held during SEND is ignored
    idle_row(1'b1, 32'h10, 32'h10);
    for (int k = 0; k < N; k++)
      send_row(1'b1, 32'hFF00_0000, 1'b1, 32'h10 + k, k);
    idle_row(1'b1, 32'hFF00_0000, 32'h10);
    for (int k = 0; k < N; k++)
      send_row(1'b0, 32'h0, 1'b1, 32'hFF00_0000 + k, k);
    // Test 5: reset after 0x13 accepted, then frame 0xA0..
    idle_row(1'b1, 32'h10, 32'hFF00_0000);
    for (int k = 0; k < 4; k++) send_row(1'b0, 32'h0, 1'b1, 32'h10 + k, k);
    vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b0));
    idle_row(1'b1, 32'hA0, 32'h0);
    for (int k = 0; k < N; k++) send_row(1'b0, 32'h0, 1'b1, 32'hA0 + k, k);
    idle_row(1'b0, 32'h0, 32'hA0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_recv_rdy", W'(recv_rdy), 32'h1);
    chk("rst_send_val", W'(send_val), 32'h0);
    chk("rst_send_msg", send_msg, 32'h0);
    chk("rst_send_last", W'(send_last), 32'h0);

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      recv_val = vecs[i].rv;
      send_rdy = vecs[i].sr;
      set_frame(vecs[i].base);
      chk($sformatf("v%0d_recv_rdy", i), W'(recv_rdy), W'(vecs[i].e_rdy));
      chk($sformatf("v%0d_send_val", i), W'(send_val), W'(vecs[i].e_val));
      chk($sformatf("v%0d_send_msg", i), send_msg, vecs[i].e_msg);
      chk($sformatf("v%0d_send_last", i), W'(send_last), W'(vecs[i].e_last));
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    recv_val = 1'b0;
    send_rdy = 1'b0;

    // Test 6a: N=1 build, one word with last, backpressure one cycle
    chk("n1_idle_rdy", W'(recv_rdy1), 32'h1);
    recv_val1    = 1'b1;
    recv_msg1[0] = 8'h5A;
    @(posedge clk); #1;
    recv_val1    = 1'b0;
    recv_msg1[0] = 8'h00;
    chk("n1_val", W'(send_val1), 32'h1);
    chk("n1_rdy", W'(recv_rdy1), 32'h0);
    chk("n1_msg", W'(send_msg1), 32'h5A);
    chk("n1_last", W'(send_last1), 32'h1);
    @(posedge clk); #1;
    chk("n1_hold_msg", W'(send_msg1), 32'h5A);
    chk("n1_hold_last", W'(send_last1), 32'h1);
    send_rdy1 = 1'b1;
    @(posedge clk); #1;
    send_rdy1 = 1'b0;
    chk("n1_done_val", W'(send_val1), 32'h0);
    chk("n1_done_rdy", W'(recv_rdy1), 32'h1);

    // Test 6b: 100 random frames with random gaps against a word queue
    begin
      int frames = 0;
      int cyc = 0;
      logic [W-1:0] nxt [N-1:0];
      for (int i = 0; i < N; i++) nxt[i] = $urandom;
      while ((frames < 100 || mq.size() != 0) && cyc < 20000) begin
        recv_val = (frames < 100) && ($urandom_range(0, 3) != 0);
        send_rdy = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < N; i++) recv_msg[i] = nxt[i];
        if (send_val && send_rdy) begin
          if (mq.size() == 0) begin
            chk("rnd_spurious_word", send_msg, 32'hDEAD_BEEF);
          end else begin
            logic [W-1:0] em;
            bit el;
            em = mq.pop_front();
            el = lq.pop_front();
            chk("rnd_msg", send_msg, em);
            chk("rnd_last", W'(send_last), W'(el));
          end
        end
        if (recv_val && recv_rdy) begin
          for (int i = 0; i < N; i++) begin
            mq.push_back(nxt[i]);
            lq.push_back(i == N - 1);
            nxt[i] = $urandom;
          end
          frames++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk("rnd_frames", W'(frames), 32'd100);
      chk("rnd_drained", W'(mq.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial stage that pairs with the deserializer in the SERDES path.
- Accepts one frame of N_SAMPLES words in a single val/rdy transfer, registers the frame, then emits it one word per accepted transfer on a val/rdy stream, index 0 first.
- Sits downstream of a parallel producer and feeds a serial consumer; its send side connects directly to the deserializer's recv side for loopback.

Parameters:
- N_SAMPLES, 8, number of words per frame; must be >= 1.
- BIT_WIDTH, 32, width of each word in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- recv_val  input  1  frame on recv_msg is valid.
- recv_rdy  output  1  block can capture a frame.
- recv_msg  input  BIT_WIDTH x N_SAMPLES (unpacked array [N_SAMPLES-1:0])  frame words; index 0 is sent first.
- send_val  output  1  send_msg is valid.
- send_rdy  input  1  consumer accepts send_msg.
- send_msg  output  BIT_WIDTH  current serial word.
- send_last  output  1  high with the final word of a frame.

Behaviour:
- Storage: N_SAMPLES registers of BIT_WIDTH, each reset to 0.
- Index counter: width max(1, $clog2(N_SAMPLES)), reset to 0.
- State register: IDLE or SEND, reset to IDLE.
- Reset values of outputs: recv_rdy=1, send_val=0, send_msg=0 (register 0 after reset), send_last=0.
- Transfer rule: a transfer occurs on a clock edge where val && rdy on that interface; there is no other transfer condition.
- IDLE outputs: recv_rdy=1, send_val=0, send_last=0.
- IDLE, recv_val=1:
  - load all N_SAMPLES registers from recv_msg in the same edge;
  - set index to 0;
  - next state is SEND.
- IDLE, recv_val=0: hold state; registers unchanged.
- SEND outputs:
  - recv_rdy=0, send_val=1;
  - send_msg = reg[index], combinational from registers;
  - send_last = (index == N_SAMPLES-1).
- SEND, send_rdy=1 and index < N_SAMPLES-1: index increments by 1.
- SEND, send_rdy=1 and index == N_SAMPLES-1: index goes to 0 and next state is IDLE.
- SEND, send_rdy=0 (backpressure): index, registers and send_msg hold stable.
- Latency: first word is valid on the cycle after capture.
- Throughput: with send_rdy held high, one frame every N_SAMPLES+1 cycles. The bubble cycle in IDLE is intentional; there is no combinational path from send_rdy to recv_rdy.
- recv_val and recv_msg are ignored in SEND; registers are written only on the IDLE capture.
- N_SAMPLES=1: SEND lasts one accepted transfer and send_last=1 throughout.
- Index never exceeds N_SAMPLES-1; there is no wrap except the last-word return to IDLE.
- Reset mid-frame: the frame is aborted. On the next cycle all outputs take their reset values, registers read 0 and index is 0. There is no partial resume.
- Reset has priority over every transfer in the same cycle.

Test Plan:
1. Assert reset 2 cycles, then release -> recv_rdy=1, send_val=0, send_msg=0, send_last=0; state stays IDLE with recv_val=0.
2. N=8, W=32; frame 0x10..0x17 with recv_val=1 for one cycle; send_rdy=1 -> send_msg reads 0x10..0x17 on cycles 1..8 after capture; send_last=1 only with 0x17; recv_rdy=0 on cycles 1..8 and 1 on cycle 9.
3. Backpressure: as test 2, with send_rdy=0 for 3 cycles while 0x12 is shown -> send_msg holds 0x12 and send_val=1 for those cycles; 0x13 follows after send_rdy rises; total frame takes 11 cycles.
4. During SEND, drive recv_val=1 with recv_msg=0xFF.. words -> recv_rdy=0, the emitted stream stays 0x10..0x17, and the next capture occurs only in IDLE.
5. Reset asserted after 0x13 is accepted -> next cycle send_val=0, recv_rdy=1, send_msg=0; a new frame 0xA0..0xA7 is then sent starting from 0xA0.
6. N=1 build: frame {0x5A} -> one send_val cycle with send_msg=0x5A and send_last=1, then IDLE. Loopback (N=8) into the deserializer with random send_rdy/recv_val gaps over 100 frames -> deserializer output frames equal the input frames.
